// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- load/store unit controller between the pipeline and a single-port
// data memory with combinational read data.
//
// Each accepted request is checked for a legal size, natural alignment and a
// data-memory window hit. A legal request makes one memory access. An illegal
// one goes straight to an error response. The response is held until the
// consumer takes it.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_valid_i/ready_o  request handshake (ready only while idle)
//   req_we_i             1 = store, 0 = load
//   req_size_i           00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i       zero-extend loaded byte/half
//   req_addr_i           byte address
//   req_wdata_i          right-aligned store data
//   rsp_valid_o/ready_i  response handshake
//   rsp_rdata_o          extended load data (0 for stores and errors)
//   rsp_err_o            misaligned, illegal size or out-of-window
//   dmem_*               data-memory native port, active only in ACCESS
// -----------------------------------------------------------------------------
package memory_pkg;
  localparam logic [31:0] MAP_DMEM_BASE   = 32'h0001_0000;
  localparam logic [31:0] DMEM_SIZE_BYTES = 32'h0000_1000;
endpackage

// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request; request fields captured on accept
// ACCESS | single-cycle data-memory access; load data captured
// RESP   | response held on rsp_* until rsp_ready_i
module lsu_ctrl #(
  parameter logic [31:0] DMEM_BASE = memory_pkg::MAP_DMEM_BASE,
  parameter logic [31:0] DMEM_SIZE = memory_pkg::DMEM_SIZE_BYTES
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  logic [1:0]  state_q, state_d;
  logic        accept;

  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;

  // Request checks, evaluated on the live request fields.
  logic        size_bad;
  logic        misaligned;
  logic        out_of_window;
  logic        req_err;
  logic [32:0] addr_ext;
  logic [32:0] win_lo;
  logic [32:0] win_hi;

  // Access-cycle datapath.
  logic [3:0]  store_be;
  logic [31:0] store_lanes;
  logic [31:0] rd_byte_sh;
  logic [31:0] rd_half_sh;
  logic [31:0] load_ext;
  logic        in_access;

  assign req_ready_o = (state_q == IDLE);
  assign accept      = req_valid_i && req_ready_o;

  // One extra bit so BASE+SIZE at the top of the address space cannot wrap.
  assign addr_ext = {1'b0, req_addr_i};
  assign win_lo   = {1'b0, DMEM_BASE};
  assign win_hi   = {1'b0, DMEM_BASE} + {1'b0, DMEM_SIZE};

  assign size_bad      = (req_size_i == SZ_BAD);
  assign misaligned    = ((req_size_i == SZ_HALF) && req_addr_i[0]) ||
                         ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
  assign out_of_window = (addr_ext < win_lo) || (addr_ext >= win_hi);
  assign req_err       = size_bad || misaligned || out_of_window;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = req_err ? RESP : ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields are only written on accept, so anything on req_* while
  // busy is ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we_i;
      size_q  <= req_size_i;
      uns_q   <= req_unsigned_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
      err_q   <= req_err;
    end
  end

  // Store byte enables and lane replication. The memory picks the lanes it
  // needs using the enables.
  always_comb begin
    store_be    = 4'b1111;
    store_lanes = wdata_q;
    unique case (size_q)
      SZ_BYTE: begin
        store_be    = 4'b0001 << addr_q[1:0];
        store_lanes = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        store_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        store_lanes = {2{wdata_q[15:0]}};
      end
      default: begin
        store_be    = 4'b1111;
        store_lanes = wdata_q;
      end
    endcase
  end

  // Load alignment: shift the addressed lane down to bit 0, then extend.
  assign rd_byte_sh = dmem_rdata_i >> {addr_q[1:0], 3'b000};
  assign rd_half_sh = dmem_rdata_i >> {addr_q[1], 4'b0000};

  always_comb begin
    load_ext = dmem_rdata_i;
    unique case (size_q)
      SZ_BYTE: load_ext = {{24{~uns_q & rd_byte_sh[7]}}, rd_byte_sh[7:0]};
      SZ_HALF: load_ext = {{16{~uns_q & rd_half_sh[15]}}, rd_half_sh[15:0]};
      default: load_ext = dmem_rdata_i;
    endcase
  end

  // Response data: cleared on accept so that an error response reads 0, and
  // loaded from memory at the end of ACCESS (stores leave it at 0).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= 32'h0;
    end else if (accept) begin
      rdata_q <= 32'h0;
    end else if (state_q == ACCESS) begin
      rdata_q <= we_q ? 32'h0 : load_ext;
    end
  end

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : 32'h0;
  assign rsp_err_o   = rsp_valid_o && err_q;

  // The memory port is decoded from state, so an asynchronous reset in
  // ACCESS drops dmem_req_o right away and the write never reaches the
  // next edge.
  assign in_access    = (state_q == ACCESS);
  assign dmem_req_o   = in_access;
  assign dmem_we_o    = in_access && we_q;
  assign dmem_be_o    = in_access ? (we_q ? store_be : 4'b1111) : 4'b0000;
  assign dmem_addr_o  = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dmem_wdata_o = (in_access && we_q) ? store_lanes : 32'h0;

endmodule
